led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 138 +++++++++++++
 tb/tb_led_pattern_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// LED pattern generator: button-selected rotate/center/bounce patterns stepped
// by a prescaled tick, with speed, direction and pause controls.
module led_pattern_gen #(
  parameter int N_LED = 12,
  parameter int DIV_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       btn_n,
  input  logic [1:0]       speed,
  input  logic             dir,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic [2:0]       mode,
  output logic             tick
);

  localparam int H = N_LED / 2;

  localparam logic [N_LED-1:0] SEED_ONE    = {{(N_LED-1){1'b0}}, 1'b1};
  localparam logic [N_LED-1:0] SEED_DARK   = ~SEED_ONE;
  localparam logic [N_LED-1:0] SEED_CENTER = (SEED_ONE << H) | (SEED_ONE << (H - 1));
  localparam logic [N_LED-1:0] SEED_BOUNCE = SEED_ONE << (N_LED - 1);

  typedef enum logic [2:0] {
    M_IDLE     = 3'd0,
    M_ROT_ONE  = 3'd1,
    M_ROT_DARK = 3'd2,
    M_CENTER   = 3'd3,
    M_BOUNCE   = 3'd4
  } mode_e;

  // Synchronizer stores the inverted (active-high) button levels, so a
  // cleared flop means "released".
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       prev_q, prev_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  mode_e            mode_q, mode_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             bup_q, bup_d;

  logic [3:0]       rise;
  logic             press;
  logic [2:0]       shamt;
  logic [DIV_W-1:0] tick_mask;
  logic             step;
  logic [H-1:0]     upper, lower;

  always_comb begin
    sync1_d   = ~btn_n;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    rise      = sync2_q & ~prev_q;
    press     = (rise != 4'd0) && $onehot(sync2_q);
    presc_d   = presc_q + DIV_W'(1);
    shamt     = {speed, 1'b0};
    // Mask keeps the low DIV_W-2*speed bits; an empty mask ticks every clock.
    tick_mask = {DIV_W{1'b1}} >> shamt;
    tick_d    = (presc_q & tick_mask) == tick_mask;
    step      = tick_d && !pause && (mode_q != M_IDLE);
  end

  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    bup_d  = bup_q;
    upper  = led_q[N_LED-1:H];
    lower  = led_q[H-1:0];
    if (press) begin
      bup_d = 1'b0;
      case (sync2_q)
        4'b0001: begin mode_d = M_ROT_ONE;  led_d = SEED_ONE;    end
        4'b0010: begin mode_d = M_ROT_DARK; led_d = SEED_DARK;   end
        4'b0100: begin mode_d = M_CENTER;   led_d = SEED_CENTER; end
        default: begin mode_d = M_BOUNCE;   led_d = SEED_BOUNCE; end
      endcase
    end else if (step) begin
      case (mode_q)
        M_ROT_ONE, M_ROT_DARK: begin
          led_d = dir ? {led_q[N_LED-2:0], led_q[N_LED-1]}
                      : {led_q[0], led_q[N_LED-1:1]};
        end
        M_CENTER: begin
          led_d = dir ? {upper[0], upper[H-1:1], lower[H-2:0], lower[H-1]}
                      : {upper[H-2:0], upper[H-1], lower[0], lower[H-1:1]};
        end
        M_BOUNCE: begin
          // Turn around as soon as an end is lit so each end shows for one step.
          if (!bup_q) begin
            if (led_q[0]) begin
              led_d = led_q << 1;
              bup_d = 1'b1;
            end else begin
              led_d = led_q >> 1;
            end
          end else begin
            if (led_q[N_LED-1]) begin
              led_d = led_q >> 1;
              bup_d = 1'b0;
            end else begin
              led_d = led_q << 1;
            end
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'd0;
      sync2_q <= 4'd0;
      prev_q  <= 4'd0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      mode_q  <= M_IDLE;
      led_q   <= SEED_ONE;
      bup_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      bup_q   <= bup_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (N_LED=12, DIV_W=4): behavioural model compared
// every clock, directed literal sequences, then randomized buttons/controls.
module tb_led_pattern_gen;

  localparam int N   = 12;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   btn_n;
  logic [1:0]   speed;
  logic         dir;
  logic         pause;
  logic [N-1:0] led;
  logic [2:0]   mode;
  logic         tick;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  led_pattern_gen #(.N_LED(N), .DIV_W(DIV)) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .speed(speed), .dir(dir),
    .pause(pause), .led(led), .mode(mode), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_led;
  int           m_mode;
  bit           m_tick;
  int           m_edges;
  int           m_pos;
  bit           m_up;
  logic [3:0]   h0, h1, h2;

  function automatic logic [N-1:0] rot(input logic [N-1:0] v, input logic up);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (up) r[(i + 1) % N] = v[i];
      else    r[(i + N - 1) % N] = v[i];
    return r;
  endfunction

  function automatic logic [N-1:0] ctr(input logic [N-1:0] v, input logic d);
    logic [N-1:0] r;
    int hh;
    hh = N / 2;
    r = '0;
    for (int i = 0; i < hh; i++)
      r[d ? (i + 1) % hh : (i + hh - 1) % hh] = v[i];
    for (int p = 0; p < hh; p++)
      r[hh + (d ? (p + hh - 1) % hh : (p + 1) % hh)] = v[hh + p];
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_led = 12'h001; m_mode = 0; m_tick = 1'b0; m_edges = 0;
      m_pos = 0; m_up = 1'b0; h0 = '0; h1 = '0; h2 = '0;
    end else begin : step_model
      logic [3:0] b;
      bit prs, tk;
      int per, sh;
      b   = h1;
      prs = ((b & ~h2) != 4'd0) && ($countones(b) == 1);
      sh  = DIV - 2 * int'(speed);
      per = (sh > 0) ? (1 << sh) : 1;
      tk  = ((m_edges + 1) % per) == 0;
      if (prs) begin
        m_up = 1'b0;
        case (b)
          4'b0001: begin m_mode = 1; m_led = 12'h001; end
          4'b0010: begin m_mode = 2; m_led = 12'hFFE; end
          4'b0100: begin m_mode = 3; m_led = 12'h060; end
          default: begin m_mode = 4; m_pos = N - 1; m_led = 12'h800; end
        endcase
      end else if (tk && !pause && m_mode != 0) begin
        if (m_mode == 1 || m_mode == 2) m_led = rot(m_led, dir);
        else if (m_mode == 3) m_led = ctr(m_led, dir);
        else begin
          if (!m_up) begin
            if (m_pos == 0) begin m_up = 1'b1; m_pos = 1; end
            else m_pos--;
          end else begin
            if (m_pos == N - 1) begin m_up = 1'b0; m_pos = N - 2; end
            else m_pos++;
          end
          m_led = '0;
          m_led[m_pos] = 1'b1;
        end
      end
      m_tick = tk;
      h2 = h1; h1 = h0; h0 = ~btn_n;
      m_edges++;
    end
  end

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("model_led", 32'(led), 32'(m_led));
      chk("model_mode", 32'(mode), 32'(m_mode));
      chk("model_tick", 32'(tick), 32'(m_tick));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_tick(output int c);
    bit found;
    found = 1'b0;
    c = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(posedge clk); #2;
      if (tick) begin found = 1'b1; c = i; end
    end
    if (!found) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic press_seed(input int b, input logic [N-1:0] seed, input int md);
    @(negedge clk);
    btn_n = 4'hF;
    btn_n[b] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("seed_led", 32'(led), 32'(seed));
    chk("seed_mode", 32'(mode), 32'(md));
    @(negedge clk);
    btn_n = 4'hF;
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] ctr_seq [6] = '{12'h090, 12'h108, 12'h204, 12'h402, 12'h801, 12'h060};

  initial begin : main
    int c;
    rst = 1'b0; btn_n = 4'hF; speed = 2'd0; dir = 1'b0; pause = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_led", 32'(led), 32'h001);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);

    @(negedge clk); rst = 1'b1;
    wait_tick(c);
    chk("first_tick_latency", c, 16);

    // Rotate one, toward LSB
    press_seed(0, 12'h001, 1);
    wait_tick(c); chk("rot1_step1", 32'(led), 32'h800);
    wait_tick(c); chk("rot1_step2", 32'(led), 32'h400);
    chk("tick_period_s0", c, 16);
    @(negedge clk); speed = 2'd1;
    wait_tick(c);
    wait_tick(c); chk("tick_period_s1", c, 4);
    @(negedge clk); speed = 2'd0;

    // Center pattern
    wait_tick(c);
    press_seed(2, 12'h060, 3);
    for (int i = 0; i < 6; i++) begin
      wait_tick(c);
      chk($sformatf("center_%0d", i), 32'(led), 32'(ctr_seq[i]));
    end
    @(negedge clk); dir = 1'b1;
    wait_tick(c); chk("center_dir1", 32'(led), 32'h801);
    @(negedge clk); dir = 1'b0;

    // Bounce
    wait_tick(c);
    press_seed(3, 12'h800, 4);
    for (int i = 1; i <= 22; i++) begin
      wait_tick(c);
      if (i == 11) chk("bounce_bottom", 32'(led), 32'h001);
      if (i == 12) chk("bounce_turn", 32'(led), 32'h002);
      if (i == 22) chk("bounce_back_top", 32'(led), 32'h800);
    end

    // Two buttons at once are ignored
    @(negedge clk); btn_n = 4'b1100;
    repeat (5) @(posedge clk);
    #2;
    chk("multi_mode", 32'(mode), 32'd4);
    chk("multi_led", 32'(led), 32'h800);
    @(negedge clk); btn_n = 4'hF;

    // Pause freezes pattern, tick keeps pulsing
    @(negedge clk); pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tick(c);
      chk("pause_tick_period", c <= 16, 32'd1);
    end
    chk("pause_led", 32'(led), 32'h800);
    @(negedge clk); pause = 1'b0;

    // Rotate-dark press landing on a tick clock: seed wins
    wait_tick(c);
    repeat (13) @(posedge clk);
    @(negedge clk); btn_n = 4'b1101;
    repeat (3) @(posedge clk);
    #2;
    chk("dark_on_tick_tick", 32'(tick), 32'd1);
    chk("dark_on_tick_led", 32'(led), 32'hFFE);
    chk("dark_on_tick_mode", 32'(mode), 32'd2);
    @(negedge clk); btn_n = 4'hF;
    wait_tick(c);
    chk("dark_step", 32'(led), 32'h7FF);
    chk("dark_period", c, 16);

    // Asynchronous reset mid-pattern
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'h001);
    chk("async_rst_mode", 32'(mode), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_tick(c);
    chk("rst_release_latency", c, 16);
    chk("rst_release_led", 32'(led), 32'h001);

    // Randomized buttons and controls, checked by the model every clock
    for (int s = 0; s < 300; s++) begin
      int r, hold;
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r < 6) btn_n = 4'hF;
      else if (r < 9) begin btn_n = 4'hF; btn_n[$urandom_range(0, 3)] = 1'b0; end
      else btn_n = 4'($urandom);
      if ($urandom_range(0, 7) == 0) speed = 2'($urandom);
      dir   = 1'($urandom);
      pause = ($urandom_range(0, 3) == 0);
      if (s == 150) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
      hold = $urandom_range(1, 10);
      repeat (hold) @(posedge clk);
    end
    @(negedge clk); btn_n = 4'hF;
    repeat (4) @(posedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
